// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch vs. data access, single-port
// memory with 1-cycle read latency, data priority with fetch anti-starvation.
module mem_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  // memory side
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [31:0]       mem_rdata,
  // pipeline control and debug
  output logic              stall_if,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is accepted in the cycle where req=1 and gnt=1; the
  // requester holds req/addr/data until then and nothing unaccepted is latched.
  // Read data follows exactly one cycle after the accepting cycle.

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_IF = 2'd1,
    S_RD_D  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             fetch_wins;
  logic             gnt_if, gnt_d;

  // Grant decision: data normally wins; a fetch that has waited the limit wins.
  always_comb begin
    fetch_wins = if_req & (~d_req | (starve_q == LIMIT));
    gnt_if     = ~reset & fetch_wins;
    gnt_d      = ~reset & d_req & ~fetch_wins;
  end

  always_comb begin
    starve_d = starve_q;
    if (gnt_if || !if_req) begin
      starve_d = '0;
    end else if (gnt_d && (starve_q != LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: identical from every state, so a new read may be granted
  // in the same cycle the previous one returns.
  always_comb begin
    state_d = S_IDLE;
    if (gnt_if) begin
      state_d = S_RD_IF;
    end else if (gnt_d && !d_we) begin
      state_d = S_RD_D;
    end
  end

  // FSM outputs and memory command mux
  always_comb begin
    if_gnt    = gnt_if;
    d_gnt     = gnt_d;
    stall_if  = ~reset & if_req & ~gnt_if;
    if_rvalid = ~reset & (state_q == S_RD_IF);
    d_rvalid  = ~reset & (state_q == S_RD_D);
    if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    d_rdata   = d_rvalid ? mem_rdata : 32'h0;
    dbg_state = state_q;

    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    mem_func3 = 3'b000;
    if (gnt_if) begin
      mem_re    = 1'b1;
      mem_addr  = if_addr;
      mem_func3 = 3'b010;
    end else if (gnt_d) begin
      mem_re    = ~d_we;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_func3 = d_func3;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (pending-read tag and a wait counter).
module tb_mem_arbiter;

  localparam int ADDR_W = 9;
  localparam int LIMIT  = 4;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req, d_we;
  logic [2:0]        d_func3;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt, d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_re, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        mem_func3;
  logic [31:0]       mem_rdata;
  logic              stall_if;
  logic [1:0]        dbg_state;

  int vec_count;
  int miscompares;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: who owns the outstanding read (0 none, 1 fetch, 2 load)
  // and how many data grants in a row a waiting fetch has lost
  int                pend_m;
  int                starve_m;
  logic              e_if_gnt, e_d_gnt, e_stall, e_if_rvalid, e_d_rvalid;
  logic              e_re, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [31:0]       e_wdata, e_if_rdata, e_d_rdata;
  logic [2:0]        e_func3;

  function automatic void model_comb();
    bit fw;
    e_if_gnt = 0; e_d_gnt = 0; e_stall = 0; e_if_rvalid = 0; e_d_rvalid = 0;
    e_re = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_func3 = '0;
    e_if_rdata = '0; e_d_rdata = '0;
    if (!reset) begin
      fw       = if_req && (!d_req || starve_m == LIMIT);
      e_if_gnt = fw;
      e_d_gnt  = d_req && !fw;
      e_stall  = if_req && !fw;
      if (e_if_gnt) begin
        e_re = 1; e_addr = if_addr; e_func3 = 3'b010;
      end else if (e_d_gnt) begin
        e_re = !d_we; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_func3 = d_func3;
      end
      e_if_rvalid = (pend_m == 1);
      e_d_rvalid  = (pend_m == 2);
      if (e_if_rvalid) e_if_rdata = mem_rdata;
      if (e_d_rvalid) e_d_rdata = mem_rdata;
    end
  endfunction

  function automatic void model_update();
    model_comb();
    if (reset) begin
      pend_m = 0; starve_m = 0;
    end else begin
      pend_m = e_if_gnt ? 1 : ((e_d_gnt && !d_we) ? 2 : 0);
      if (e_if_gnt || !if_req) starve_m = 0;
      else if (e_d_gnt && starve_m < LIMIT) starve_m = starve_m + 1;
    end
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_func3 = '0;
    d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      if_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
      d_we = 1'($urandom_range(0, 1)); if_addr = ADDR_W'($urandom);
      d_addr = ADDR_W'($urandom); d_wdata = $urandom; d_func3 = 3'($urandom);
      mem_rdata = $urandom | 32'h1;
      @(negedge clk);
      vec_count++;
      if ({if_gnt, d_gnt, if_rvalid, d_rvalid, stall_if, mem_re, mem_we, mem_addr,
           mem_wdata, mem_func3, if_rdata, d_rdata} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs: gnt=%b/%b rv=%b/%b stall=%b re=%b we=%b addr=%h wd=%h f3=%h rd=%h/%h, want all 0",
                 if_gnt, d_gnt, if_rvalid, d_rvalid, stall_if, mem_re, mem_we, mem_addr,
                 mem_wdata, mem_func3, if_rdata, d_rdata);
      end
      tick();
    end
    reset = 0;
    idle_inputs();
    tick();
  endtask

  task automatic test_fetch_only();
    if_req = 1; if_addr = 9'h010;
    @(negedge clk);
    vec_count++;
    if ({if_gnt, d_gnt, stall_if, mem_re, mem_we, mem_addr, mem_func3} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'h010, 3'b010}) begin
      miscompares++;
      $display("FAIL fetch_grant: gnt=%b dgnt=%b stall=%b re=%b we=%b addr=%h f3=%b, want 1 0 0 1 0 010 010",
               if_gnt, d_gnt, stall_if, mem_re, mem_we, mem_addr, mem_func3);
    end
    tick();
    if_req = 0; mem_rdata = 32'h00500093;
    @(negedge clk);
    vec_count++;
    if ({if_rvalid, if_rdata, d_rvalid} !== {1'b1, 32'h00500093, 1'b0}) begin
      miscompares++;
      $display("FAIL fetch_return: if_rvalid=%b if_rdata=%h d_rvalid=%b, want 1 00500093 0",
               if_rvalid, if_rdata, d_rvalid);
    end
    tick();
    @(negedge clk);
    vec_count++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL fetch_after: if_rvalid=%b if_rdata=%h, want 0 00000000", if_rvalid, if_rdata);
    end
    tick();
  endtask

  task automatic test_conflict();
    logic [31:0] r1, r2;
    r1 = $urandom; r2 = $urandom;
    if_req = 1; if_addr = 9'h020;
    d_req = 1; d_we = 0; d_addr = 9'h040; d_func3 = 3'b010;
    @(negedge clk);
    vec_count++;
    if ({if_gnt, d_gnt, stall_if, mem_re, mem_addr} !== {1'b0, 1'b1, 1'b1, 1'b1, 9'h040}) begin
      miscompares++;
      $display("FAIL conflict_data_first: if_gnt=%b d_gnt=%b stall=%b re=%b addr=%h, want 0 1 1 1 040",
               if_gnt, d_gnt, stall_if, mem_re, mem_addr);
    end
    tick();
    d_req = 0; mem_rdata = r1;
    @(negedge clk);
    vec_count++;
    if ({d_rvalid, d_rdata, if_gnt, stall_if, mem_addr} !== {1'b1, r1, 1'b1, 1'b0, 9'h020}) begin
      miscompares++;
      $display("FAIL conflict_second: d_rvalid=%b d_rdata=%h if_gnt=%b stall=%b addr=%h, want 1 %h 1 0 020",
               d_rvalid, d_rdata, if_gnt, stall_if, mem_addr, r1);
    end
    tick();
    if_req = 0; mem_rdata = r2;
    @(negedge clk);
    vec_count++;
    if ({if_rvalid, if_rdata, d_rvalid} !== {1'b1, r2, 1'b0}) begin
      miscompares++;
      $display("FAIL conflict_fetch_return: if_rvalid=%b if_rdata=%h d_rvalid=%b, want 1 %h 0",
               if_rvalid, if_rdata, d_rvalid, r2);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    idle_inputs();
    tick();
    if_req = 1; if_addr = 9'h100;
    d_req = 1; d_we = 0; d_addr = 9'h0c0; d_func3 = 3'b010;
    for (int c = 1; c <= 6; c++) begin
      logic [1:0] want;
      want = (c == 5) ? 2'b10 : 2'b01;
      @(negedge clk);
      vec_count++;
      if ({if_gnt, d_gnt} !== want) begin
        miscompares++;
        $display("FAIL starve_cycle%0d: {if_gnt,d_gnt}=%b, want %b", c, {if_gnt, d_gnt}, want);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_store();
    d_req = 1; d_we = 1; d_addr = 9'h080; d_wdata = 32'hDEADBEEF; d_func3 = 3'b010;
    @(negedge clk);
    vec_count++;
    if ({d_gnt, mem_we, mem_re, mem_addr, mem_wdata, mem_func3} !==
        {1'b1, 1'b1, 1'b0, 9'h080, 32'hDEADBEEF, 3'b010}) begin
      miscompares++;
      $display("FAIL store_cmd: gnt=%b we=%b re=%b addr=%h wd=%h f3=%b, want 1 1 0 080 deadbeef 010",
               d_gnt, mem_we, mem_re, mem_addr, mem_wdata, mem_func3);
    end
    tick();
    idle_inputs(); mem_rdata = 32'h12345678;
    @(negedge clk);
    vec_count++;
    if ({d_rvalid, d_rdata} !== {1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL store_no_rvalid: d_rvalid=%b d_rdata=%h, want 0 00000000", d_rvalid, d_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    r1 = $urandom; r2 = $urandom;
    if_req = 1; if_addr = 9'h030;
    @(negedge clk);
    vec_count++;
    if (if_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_fetch_gnt: if_gnt=%b, want 1", if_gnt);
    end
    tick();
    if_req = 0; d_req = 1; d_we = 0; d_addr = 9'h044; d_func3 = 3'b100; mem_rdata = r1;
    @(negedge clk);
    vec_count++;
    if ({if_rvalid, if_rdata, d_gnt, mem_re, mem_addr, mem_func3} !==
        {1'b1, r1, 1'b1, 1'b1, 9'h044, 3'b100}) begin
      miscompares++;
      $display("FAIL b2b_overlap: if_rvalid=%b if_rdata=%h d_gnt=%b re=%b addr=%h f3=%b, want 1 %h 1 1 044 100",
               if_rvalid, if_rdata, d_gnt, mem_re, mem_addr, mem_func3, r1);
    end
    tick();
    d_req = 0; mem_rdata = r2;
    @(negedge clk);
    vec_count++;
    if ({d_rvalid, d_rdata, if_rvalid} !== {1'b1, r2, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_load_return: d_rvalid=%b d_rdata=%h if_rvalid=%b, want 1 %h 0",
               d_rvalid, d_rdata, if_rvalid, r2);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    if_req = 1; if_addr = 9'h050;
    @(negedge clk);
    vec_count++;
    if (if_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_fetch_gnt: if_gnt=%b, want 1", if_gnt);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      reset = (c == 0); if_req = 0; mem_rdata = $urandom | 32'h1;
      @(negedge clk);
      vec_count++;
      if ({if_gnt, d_gnt, if_rvalid, d_rvalid, stall_if, mem_re, mem_we, mem_addr,
           mem_wdata, mem_func3, if_rdata, d_rdata} !== '0) begin
        miscompares++;
        $display("FAIL midrst_cycle%0d: if_rvalid=%b if_rdata=%h gnt=%b/%b re=%b addr=%h, want all 0",
                 c + 1, if_rvalid, if_rdata, if_gnt, d_gnt, mem_re, mem_addr);
      end
      tick();
    end
    reset = 0;
  endtask

  // scoreboard-style random run: every cycle every output checked against the model
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset   = ($urandom_range(0, 49) == 0);
      if_req  = ($urandom_range(0, 3) != 0);
      d_req   = ($urandom_range(0, 3) != 0);
      d_we    = ($urandom_range(0, 2) == 0);
      if_addr = ADDR_W'($urandom); d_addr = ADDR_W'($urandom);
      d_wdata = $urandom; d_func3 = 3'($urandom); mem_rdata = $urandom;
      @(negedge clk);
      model_comb();
      vec_count++;
      if ({if_gnt, d_gnt, stall_if} !== {e_if_gnt, e_d_gnt, e_stall}) begin
        miscompares++;
        $display("FAIL rand_grant c%0d: {if_gnt,d_gnt,stall}=%b, want %b (starve=%0d)",
                 c, {if_gnt, d_gnt, stall_if}, {e_if_gnt, e_d_gnt, e_stall}, starve_m);
      end
      vec_count++;
      if ({mem_re, mem_we, mem_addr, mem_wdata, mem_func3} !== {e_re, e_we, e_addr, e_wdata, e_func3}) begin
        miscompares++;
        $display("FAIL rand_memcmd c%0d: re=%b we=%b addr=%h wd=%h f3=%b, want %b %b %h %h %b",
                 c, mem_re, mem_we, mem_addr, mem_wdata, mem_func3, e_re, e_we, e_addr, e_wdata, e_func3);
      end
      vec_count++;
      if ({if_rvalid, if_rdata, d_rvalid, d_rdata} !== {e_if_rvalid, e_if_rdata, e_d_rvalid, e_d_rdata}) begin
        miscompares++;
        $display("FAIL rand_return c%0d: if %b/%h d %b/%h, want if %b/%h d %b/%h",
                 c, if_rvalid, if_rdata, d_rvalid, d_rdata, e_if_rvalid, e_if_rdata, e_d_rvalid, e_d_rdata);
      end
      tick();
    end
    reset = 0;
    idle_inputs();
    tick();
  endtask

  initial begin
    vec_count = 0; miscompares = 0;
    pend_m = 0; starve_m = 0;
    reset = 1; mem_rdata = '0;
    idle_inputs();
    tick();
    tick();
    test_reset();
    test_fetch_only();
    test_conflict();
    test_starvation();
    test_store();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, giving the memory byte-address width.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, giving the maximum consecutive data grants while a fetch waits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port if_req, input, 1 bit: instruction-fetch read request.
REQ-006 The block SHALL have port if_addr, input, ADDR_W bits: fetch address.
REQ-007 The block SHALL have port if_gnt, output, 1 bit: fetch request accepted this cycle.
REQ-008 The block SHALL have port if_rvalid, output, 1 bit: fetch data valid.
REQ-009 The block SHALL have port if_rdata, output, 32 bits: fetch data.
REQ-010 The block SHALL have port d_req, input, 1 bit: data-access request.
REQ-011 The block SHALL have port d_we, input, 1 bit: data access is a store (1) or load (0).
REQ-012 The block SHALL have port d_func3, input, 3 bits: access size/sign code.
REQ-013 The block SHALL have port d_addr, input, ADDR_W bits: data address.
REQ-014 The block SHALL have port d_wdata, input, 32 bits: store data.
REQ-015 The block SHALL have port d_gnt, output, 1 bit: data request accepted this cycle.
REQ-016 The block SHALL have port d_rvalid, output, 1 bit: load data valid.
REQ-017 The block SHALL have port d_rdata, output, 32 bits: load data.
REQ-018 The block SHALL have memory-side ports mem_re (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, 32), mem_func3 (output, 3), mem_rdata (input, 32).
REQ-019 The block SHALL have port stall_if, output, 1 bit: equals if_req & ~if_gnt, so the PC and IF/ID register hold.

Function
REQ-020 The arbiter SHALL grant at most one requester per cycle; if_gnt and d_gnt SHALL never both be 1.
REQ-021 Grants SHALL be combinational in the request cycle; the memory command SHALL be driven from the granted requester in the same cycle.
REQ-022 With no grant, mem_re, mem_we, mem_addr, mem_wdata and mem_func3 SHALL all be 0.
REQ-023 A fetch grant SHALL drive mem_re=1, mem_we=0, mem_addr=if_addr, and mem_func3=3'b010 (word).
REQ-024 A data grant SHALL drive mem_re=~d_we, mem_we=d_we, mem_addr=d_addr, mem_func3=d_func3 and mem_wdata=d_wdata.
REQ-025 The memory has 1-cycle read latency; the requester whose read was granted in cycle N SHALL see rvalid=1 and rdata=mem_rdata in cycle N+1.
REQ-026 Stores SHALL complete at grant and produce no rvalid.
REQ-027 Each rdata output SHALL be 0 whenever its rvalid is 0.
REQ-028 The state machine SHALL have three states: IDLE (no read outstanding), RD_IF (fetch read outstanding), RD_D (load outstanding).
REQ-029 The state SHALL transition as follows: a fetch grant goes to RD_IF, a load grant goes to RD_D, and a store grant or no grant goes to IDLE; the same transitions apply from every state.
REQ-030 A new grant SHALL be allowed in the same cycle a previous read returns, giving one access per cycle of throughput.
REQ-031 Priority SHALL be data over fetch, except when starve_cnt == STARVE_LIMIT, in which case the fetch wins.
REQ-032 starve_cnt SHALL saturate at STARVE_LIMIT.
REQ-033 starve_cnt SHALL increment when d_gnt=1 and if_req=1.
REQ-034 starve_cnt SHALL clear when if_gnt=1 or if_req=0.
REQ-035 Requesters hold req/addr/data stable until gnt; the arbiter SHALL NOT latch unaccepted requests.
REQ-036 A request dropped before its grant SHALL be ignored without error.

Reset
REQ-037 While reset=1 at a rising edge, state SHALL go to IDLE and starve_cnt to 0.
REQ-038 While reset=1, if_gnt, d_gnt, if_rvalid, d_rvalid, stall_if, all mem_* outputs and all rdata SHALL be 0.
REQ-039 A read outstanding when reset asserts SHALL be discarded: no rvalid in the cycle after reset deasserts.

Verification
REQ-040 Fetch only: if_req=1, if_addr=0x010, mem_rdata=0x00500093 next cycle -> if_gnt=1 with mem_addr=0x010, then if_rvalid=1 with if_rdata=0x00500093.
REQ-041 Conflict: if_req=1 and d_req=1 (load, 0x040) in the same cycle -> d_gnt=1, stall_if=1; the next cycle returns d_rvalid=1 and grants the fetch.
REQ-042 Starvation: if_req=1 and d_req=1 held for 6 cycles with STARVE_LIMIT=4 -> d_gnt in cycles 1-4, if_gnt in cycle 5, d_gnt in cycle 6.
REQ-043 Store: d_req=1, d_we=1, d_addr=0x080, d_wdata=0xDEADBEEF, d_func3=3'b010 -> mem_we=1 with those values; d_rvalid=0 the next cycle.
REQ-044 Back-to-back: a fetch in cycle N and a load in cycle N+1 -> if_rvalid in N+1 and d_rvalid in N+2, with no idle cycle between.
REQ-045 Reset mid-read: fetch granted in cycle N, reset=1 in cycle N+1 -> if_rvalid=0 in N+1 and N+2, and all outputs 0.
